input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent input channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel, minimum 2.
REQ-003 SHALL have parameter SAMPLE_CNT_MAX, default 25000: clk cycles per sample tick, minimum 1.
REQ-004 SHALL have parameter PULSE_CNT_MAX, default 200: consecutive agreeing samples needed to change debounced level, minimum 1.
REQ-005 SHALL have parameter REPEAT_DELAY, default 1000: sample ticks from press to first auto-repeat, minimum 1.
REQ-006 SHALL have parameter REPEAT_RATE, default 200: sample ticks between later auto-repeats, minimum 1.
REQ-007 SHALL have port clk, input, 1: single clock for all logic.
REQ-008 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-009 SHALL have port in, input, WIDTH: raw asynchronous inputs, e.g. buttons.
REQ-010 SHALL have port repeat_en, input, WIDTH: per-channel auto-repeat enable, synchronous to clk.
REQ-011 SHALL have port level, output, WIDTH: debounced level per channel.
REQ-012 SHALL have port pressed, output, WIDTH: one-cycle pulse on debounced rise and on each auto-repeat.
REQ-013 SHALL have port released, output, WIDTH: one-cycle pulse on debounced fall.

Function
REQ-014 SHALL pass each in bit through a SYNC_STAGES-deep flop chain; only the last stage is used downstream.
REQ-015 SHALL share one sample counter across channels: counts 0..SAMPLE_CNT_MAX-1 and wraps to 0; tick is high for the one cycle the count equals SAMPLE_CNT_MAX-1.
REQ-016 SHALL keep a per-channel disagreement counter: on a tick, if the synced input differs from level, increment; otherwise clear to 0; hold between ticks.
REQ-017 SHALL toggle level on the tick that brings the disagreement counter to PULSE_CNT_MAX, and clear that counter in the same cycle.
REQ-018 SHALL debounce press and release symmetrically; a glitch shorter than PULSE_CNT_MAX consecutive samples SHALL NOT change level.
REQ-019 SHALL register pressed/released so each pulse is high exactly in the clock cycle in which the new level first appears on level.
REQ-020 SHALL run a per-channel FSM. RELEASED: level=0. HELD_DELAY: level=1, counting to REPEAT_DELAY. HELD_REPEAT: level=1, counting to REPEAT_RATE.
REQ-021 SHALL move RELEASED->HELD_DELAY on debounced rise, with the repeat counter cleared.
REQ-022 SHALL, in HELD_DELAY with repeat_en=1, count ticks; on the REPEAT_DELAY-th tick, pulse pressed, clear the counter and go to HELD_REPEAT.
REQ-023 SHALL, in HELD_REPEAT with repeat_en=1, pulse pressed every REPEAT_RATE ticks, clearing the counter on each pulse.
REQ-024 SHALL, while repeat_en=0 in HELD_DELAY/HELD_REPEAT, hold the repeat counter at 0, emit no repeat pulses and go to HELD_DELAY.
REQ-025 SHALL move any held state to RELEASED on debounced fall; released has priority and no repeat pulse SHALL occur that cycle.
REQ-026 SHALL handle channels fully independently; simultaneous events on several channels SHALL pulse the corresponding bits in the same cycle.
REQ-027 SHALL size every counter $clog2(MAX+1) bits; counters SHALL never exceed their MAX or wrap silently.
REQ-028 SHALL have a latency from a stable input edge to level change of SYNC_STAGES cycles plus PULSE_CNT_MAX ticks, minus at most 1 tick of phase.

Reset
REQ-029 SHALL, on a clk edge with rst_n=0, clear synchronizer flops, sample counter, all per-channel counters, level, pressed and released to 0, and put all FSMs in RELEASED.
REQ-030 SHALL emit no released pulse because of reset; a reset-time input held high SHALL produce a normal pressed pulse after debounce once rst_n=1.

Verification (WIDTH=4, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-031 SHALL cover: rst_n=0 for 10 cycles with in=4'hF -> level=0, pressed=0, released=0 throughout; after rst_n=1, pressed=4'hF once after 3 ticks.
REQ-032 SHALL cover: in[0] rises and holds -> pressed=4'h1 for exactly one cycle, level[0]=1 from that cycle; in[0] falls -> released=4'h1 once ~12 cycles later.
REQ-033 SHALL cover: in[2] toggling every 5 cycles for 200 cycles -> level[2] stays 0, no pulses on channel 2.
REQ-034 SHALL cover: repeat_en[1]=1, hold in[1] -> initial press pulse, next pulse 20 cycles later, then every 8 cycles; repeat_en[1]=0 mid-hold -> pulses stop, level[1] stays 1.
REQ-035 SHALL cover: all four inputs rise in the same cycle -> pressed=4'hF in a single cycle, then 4'h0.
REQ-036 SHALL cover: rst_n=0 for 1 cycle while channel 1 is in HELD_REPEAT -> next cycle level=0, no released pulse, repeat pulses cease.

Source files
------------

// File: rtl/input_conditioner.sv
// Input conditioner: synchronizes, debounces and auto-repeats WIDTH button-style inputs.
// All channels share one sample tick; each channel owns a debounce counter and a repeat FSM.
module input_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int REPEAT_DELAY   = 1000,
  parameter int REPEAT_RATE    = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] repeat_en,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released
);

  localparam int SCW     = $clog2(SAMPLE_CNT_MAX + 1);
  localparam int PCW     = $clog2(PULSE_CNT_MAX + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW     = $clog2(REP_MAX + 1);

  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
  localparam logic [SCW-1:0] SAMPLE_ONE  = SCW'(1);
  localparam logic [PCW-1:0] PULSE_LAST  = PCW'(PULSE_CNT_MAX - 1);
  localparam logic [PCW-1:0] PULSE_ONE   = PCW'(1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RATE_LAST   = RCW'(REPEAT_RATE - 1);
  localparam logic [RCW-1:0] REP_ONE     = RCW'(1);

  localparam logic [1:0] ST_RELEASED    = 2'd0;
  localparam logic [1:0] ST_HELD_DELAY  = 2'd1;
  localparam logic [1:0] ST_HELD_REPEAT = 2'd2;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [SCW-1:0]   sample_cnt;
  logic             tick;
  logic [PCW-1:0]   dis_cnt [WIDTH];
  logic [RCW-1:0]   rep_cnt [WIDTH];
  logic [1:0]       state   [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + SAMPLE_ONE;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign tick   = (sample_cnt == SAMPLE_LAST);
  assign differ = synced ^ level;
  assign rise   = toggle & ~level;
  assign fall   = toggle & level;

  // A channel flips on the tick that would make its disagreement count reach PULSE_CNT_MAX.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = tick && differ[i] && (dis_cnt[i] == PULSE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < WIDTH; i++) dis_cnt[i] <= '0;
    end else begin
      level <= level ^ toggle;
      for (int i = 0; i < WIDTH; i++) begin
        if (tick) begin
          if (!differ[i] || toggle[i]) begin
            dis_cnt[i] <= '0;
          end else begin
            dis_cnt[i] <= dis_cnt[i] + PULSE_ONE;
          end
        end
      end
    end
  end

  // Fall outranks everything so a release never coincides with a repeat pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressed  <= '0;
      released <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state[i]   <= ST_RELEASED;
        rep_cnt[i] <= '0;
      end
    end else begin
      pressed  <= '0;
      released <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (fall[i]) begin
          state[i]    <= ST_RELEASED;
          rep_cnt[i]  <= '0;
          released[i] <= 1'b1;
        end else if (rise[i]) begin
          state[i]   <= ST_HELD_DELAY;
          rep_cnt[i] <= '0;
          pressed[i] <= 1'b1;
        end else begin
          case (state[i])
            ST_RELEASED: begin
              rep_cnt[i] <= '0;
            end
            ST_HELD_DELAY: begin
              if (!repeat_en[i]) begin
                rep_cnt[i] <= '0;
              end else if (tick) begin
                if (rep_cnt[i] == DELAY_LAST) begin
                  pressed[i] <= 1'b1;
                  rep_cnt[i] <= '0;
                  state[i]   <= ST_HELD_REPEAT;
                end else begin
                  rep_cnt[i] <= rep_cnt[i] + REP_ONE;
                end
              end
            end
            ST_HELD_REPEAT: begin
              if (!repeat_en[i]) begin
                rep_cnt[i] <= '0;
                state[i]   <= ST_HELD_DELAY;
              end else if (tick) begin
                if (rep_cnt[i] == RATE_LAST) begin
                  pressed[i] <= 1'b1;
                  rep_cnt[i] <= '0;
                end else begin
                  rep_cnt[i] <= rep_cnt[i] + REP_ONE;
                end
              end
            end
            default: begin
              rep_cnt[i] <= '0;
              state[i]   <= level[i] ? ST_HELD_DELAY : ST_RELEASED;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: sliding-window debounce model plus directed scenarios.
module tb_input_conditioner;

  localparam int SAMPLE = 4;
  localparam int PULSE  = 3;
  localparam int DELAY  = 5;
  localparam int RATE   = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_sig;
  logic [3:0] repeat_en;
  logic [3:0] level;
  logic [3:0] pressed;
  logic [3:0] released;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .WIDTH(4), .SYNC_STAGES(2), .SAMPLE_CNT_MAX(SAMPLE),
    .PULSE_CNT_MAX(PULSE), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in_sig), .repeat_en(repeat_en),
    .level(level), .pressed(pressed), .released(released)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Waits (bounded) for a pressed or released pulse on any masked bit; cycles=-1 on timeout.
  task automatic wait_pulse(input bit want_rel, input logic [3:0] mask, input int limit, output int cycles);
    cycles = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (((want_rel ? released : pressed) & mask) != 4'h0) begin
        cycles = n;
        break;
      end
    end
    if (cycles < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_pulse: no %s pulse on mask %h within %0d cycles",
               want_rel ? "released" : "pressed", mask, limit);
    end
  endtask

  // Reference model: level flips once the last PULSE tick samples all disagree with it;
  // repeats fire when enabled held-ticks k reach DELAY, then every RATE ticks.
  logic [3:0]       m_s0, m_s1, m_synced;
  logic [3:0]       m_level, m_pressed, m_released;
  logic [PULSE-1:0] m_hist [4];
  int               m_nhist [4];
  int               m_k [4];
  int               m_cyc;
  bit               m_tick, m_toggled;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s0 = 4'h0; m_s1 = 4'h0; m_cyc = 0;
      m_level = 4'h0; m_pressed = 4'h0; m_released = 4'h0;
      for (int ch = 0; ch < 4; ch++) begin
        m_hist[ch] = '0; m_nhist[ch] = 0; m_k[ch] = 0;
      end
    end else begin
      m_synced = m_s1;
      m_tick   = (m_cyc % SAMPLE) == (SAMPLE - 1);
      m_s1 = m_s0;
      m_s0 = in_sig;
      m_cyc++;
      m_pressed  = 4'h0;
      m_released = 4'h0;
      for (int ch = 0; ch < 4; ch++) begin
        m_toggled = 1'b0;
        if (m_tick) begin
          m_hist[ch] = {m_hist[ch][PULSE-2:0], m_synced[ch]};
          if (m_nhist[ch] < PULSE) m_nhist[ch]++;
          if (m_nhist[ch] == PULSE && m_hist[ch] == {PULSE{~m_level[ch]}}) begin
            m_toggled = 1'b1;
            m_nhist[ch] = 0;
          end
        end
        if (m_toggled) begin
          if (m_level[ch]) begin
            m_level[ch] = 1'b0;
            m_released[ch] = 1'b1;
          end else begin
            m_level[ch] = 1'b1;
            m_pressed[ch] = 1'b1;
            m_k[ch] = 0;
          end
        end else if (m_level[ch]) begin
          if (!repeat_en[ch]) begin
            m_k[ch] = 0;
          end else if (m_tick) begin
            m_k[ch]++;
            if (m_k[ch] >= DELAY && ((m_k[ch] - DELAY) % RATE) == 0) m_pressed[ch] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check_output("model_level", {28'h0, level}, {28'h0, m_level});
    check_output("model_pressed", {28'h0, pressed}, {28'h0, m_pressed});
    check_output("model_released", {28'h0, released}, {28'h0, m_released});
  end

  task automatic apply_stimulus();
    int   c;
    logic sticky;

    // Reset held with all inputs high, then a single debounced press.
    rst_n = 1'b0; in_sig = 4'hF; repeat_en = 4'h0;
    sticky = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (level !== 4'h0 || pressed !== 4'h0 || released !== 4'h0) sticky = 1'b1;
    end
    check_output("reset_quiet", {31'h0, sticky}, 32'h0);
    rst_n = 1'b1;
    wait_pulse(1'b0, 4'hF, 20, c);
    check_output("reset_press_latency", c, 12);
    check_output("reset_press_value", {28'h0, pressed}, 32'hF);
    @(negedge clk);
    check_output("reset_press_single", {28'h0, pressed}, 32'h0);
    in_sig = 4'h0;
    repeat (24) @(negedge clk);

    // Single channel press and release.
    in_sig[0] = 1'b1;
    wait_pulse(1'b0, 4'h1, 20, c);
    check_range("ch0_press_latency", c, 11, 14);
    check_output("ch0_press_value", {28'h0, pressed}, 32'h1);
    check_output("ch0_level_with_pulse", {31'h0, level[0]}, 32'h1);
    @(negedge clk);
    check_output("ch0_press_single", {28'h0, pressed}, 32'h0);
    repeat (8) @(negedge clk);
    in_sig[0] = 1'b0;
    wait_pulse(1'b1, 4'h1, 20, c);
    check_range("ch0_release_latency", c, 11, 14);
    check_output("ch0_release_value", {28'h0, released}, 32'h1);
    repeat (8) @(negedge clk);

    // Glitchy channel 2: runs of 5 cycles never give 3 agreeing samples.
    sticky = 1'b0;
    for (int t = 0; t < 40; t++) begin
      in_sig[2] = ~in_sig[2];
      repeat (5) begin
        @(negedge clk);
        if (level[2] !== 1'b0 || pressed[2] !== 1'b0 || released[2] !== 1'b0) sticky = 1'b1;
      end
    end
    check_output("ch2_glitch_filtered", {31'h0, sticky}, 32'h0);
    repeat (8) @(negedge clk);

    // All channels rising together.
    in_sig = 4'hF;
    wait_pulse(1'b0, 4'hF, 20, c);
    check_output("all_press_value", {28'h0, pressed}, 32'hF);
    @(negedge clk);
    check_output("all_press_single", {28'h0, pressed}, 32'h0);
    in_sig = 4'h0;
    repeat (24) @(negedge clk);

    // Auto-repeat on channel 1.
    repeat_en[1] = 1'b1;
    in_sig[1] = 1'b1;
    wait_pulse(1'b0, 4'h2, 20, c);
    check_output("ch1_first_press", {28'h0, pressed}, 32'h2);
    wait_pulse(1'b0, 4'h2, 30, c);
    check_output("ch1_repeat_delay", c, 20);
    wait_pulse(1'b0, 4'h2, 12, c);
    check_output("ch1_repeat_rate_a", c, 8);
    wait_pulse(1'b0, 4'h2, 12, c);
    check_output("ch1_repeat_rate_b", c, 8);
    repeat_en[1] = 1'b0;
    sticky = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (pressed[1] !== 1'b0 || level[1] !== 1'b1) sticky = 1'b1;
    end
    check_output("ch1_repeat_disabled", {31'h0, sticky}, 32'h0);

    // Reset while channel 1 is auto-repeating.
    repeat_en[1] = 1'b1;
    wait_pulse(1'b0, 4'h2, 30, c);
    wait_pulse(1'b0, 4'h2, 12, c);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midreset_level", {28'h0, level}, 32'h0);
    check_output("midreset_no_release", {28'h0, released}, 32'h0);
    rst_n = 1'b1;
    sticky = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (pressed !== 4'h0 || released !== 4'h0) sticky = 1'b1;
    end
    check_output("midreset_repeats_cease", {31'h0, sticky}, 32'h0);
    repeat (10) @(negedge clk);
    repeat_en = 4'h0;
    in_sig = 4'h0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
